// File: rtl/npu_dot_engine_if.sv
// Operand/result bundle of the NPU dot-product engine.
// master: operand fetch side (drives start and operand beats).
// slave : the engine (drives the handshake ready, status and result).
interface npu_dot_engine_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 3,
  parameter int ACC_W  = 72
);
  logic                      en;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in1;
  logic [LANES*DATA_W-1:0]   in2;
  logic                      busy;
  logic                      ack;
  logic [ACC_W-1:0]          out_data;
  logic                      ovf;

  modport master (
    output en, in_valid, in1, in2,
    input  in_ready, busy, ack, out_data, ovf
  );

  modport slave (
    input  en, in_valid, in1, in2,
    output in_ready, busy, ack, out_data, ovf
  );
endinterface

// File: rtl/npu_dot_engine.sv
// npu_dot_engine: signed dot product of two VEC_LEN-element vectors,
// streamed LANES elements per beat. Stage 1 registers the lane products,
// stage 2 folds their sum into the accumulator. The result is registered
// when DONE is entered and ack pulses in the cycle after DONE.
// Optional build macro: NPU_SAT_EN -- clamp the result to the signed
// DATA_W range and raise ovf when clamping happened.
module npu_dot_engine #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 3,
  parameter int VEC_LEN = 9,
  parameter int ACC_W   = 72
) (
  input  logic              clk,
  input  logic              rst,
  npu_dot_engine_if.slave   bus
);

  localparam int BEATS  = VEC_LEN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                    state_r, state_s;
  logic [CNT_W-1:0]          beat_cnt_r;
  logic signed [PROD_W-1:0]  prod_r [LANES];
  logic signed [PROD_W-1:0]  prod_s [LANES];
  logic                      pvalid_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   result_s;
  logic                      res_ovf_s;
  logic [ACC_W-1:0]          out_data_r;
  logic                      ovf_r;
  logic                      ack_r;
  logic                      busy_r;
  logic                      in_ready_r;
  logic                      accept_s;
  logic                      start_s;
  logic                      last_s;

  assign accept_s = bus.in_valid && in_ready_r;
  assign start_s  = (state_r == IDLE) && bus.en;
  assign last_s   = (beat_cnt_r == LAST_BEAT);

  // Next-state selection for the run/drain sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.en) state_s = RUN;
        else        state_s = IDLE;
      end
      RUN: begin
        if (accept_s && last_s) state_s = DRAIN1;
        else                    state_s = RUN;
      end
      DRAIN1:  state_s = DRAIN2;
      DRAIN2:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Lane products of the current beat and the sign-extended sum of stage 1.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = PROD_W'($signed(bus.in1[i*DATA_W +: DATA_W])) *
                  PROD_W'($signed(bus.in2[i*DATA_W +: DATA_W]));
      sum_s     = sum_s + ACC_W'(prod_r[i]);
    end
  end

  // Result shaping applied when the final accumulator is captured.
  always_comb begin
`ifdef NPU_SAT_EN
    if (acc_r > SAT_MAX) begin
      result_s  = SAT_MAX;
      res_ovf_s = 1'b1;
    end else if (acc_r < SAT_MIN) begin
      result_s  = SAT_MIN;
      res_ovf_s = 1'b1;
    end else begin
      result_s  = acc_r;
      res_ovf_s = 1'b0;
    end
`else
    result_s  = acc_r;
    res_ovf_s = 1'b0;
`endif
  end

  // State register and the status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == RUN);
      busy_r     <= (state_s != IDLE);
      ack_r      <= (state_r == DONE);
    end
  end

  // Beat counter: cleared on start, advanced per accepted beat.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
    end
  end

  // Stage 1: register lane products with a valid bit (bubbles leave it low).
  always_ff @(posedge clk) begin
    if (rst) begin
      pvalid_r <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_r[i] <= {PROD_W{1'b0}};
    end else begin
      pvalid_r <= accept_s && !start_s;
      if (accept_s) begin
        for (int i = 0; i < LANES; i++) prod_r[i] <= prod_s[i];
      end
    end
  end

  // Stage 2: accumulate the product sum; wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (pvalid_r) begin
      acc_r <= acc_r + sum_s;
    end
  end

  // Result capture on entry to DONE; held until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r <= {ACC_W{1'b0}};
      ovf_r      <= 1'b0;
    end else if (start_s) begin
      ovf_r      <= 1'b0;
    end else if (state_r == DRAIN2) begin
      out_data_r <= result_s;
      ovf_r      <= res_ovf_s;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;
  assign bus.ack      = ack_r;
  assign bus.out_data = out_data_r;
  assign bus.ovf      = ovf_r;

endmodule
